// File: rtl/gate_pipe_pkg.sv
// rtl/gate_pipe_pkg.sv - shared types and lane helpers for the predicate-gated multilane pipe
package gate_pipe_pkg;

   typedef enum logic {
      GATE_AND  = 1'b0,
      GATE_HOLD = 1'b1
   } gate_mode_e;

   // Bit offset of a lane inside a lane-packed vector, lane 0 in the LSBs.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/gate_pipe_multilane_stage.sv
// rtl/gate_pipe_multilane_stage.sv - one valid/ready register stage with collapsing bubbles
module gate_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   input  logic         i_ready
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // An empty stage always accepts, so bubbles are squeezed out.
   assign o_ready = !r_valid | i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_ready) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

endmodule

// File: rtl/gate_pipe_multilane.sv
// rtl/gate_pipe_multilane.sv - multilane predicate-gated valid/ready pipeline with gated-beat counter
module gate_pipe_multilane
   import gate_pipe_pkg::*;
#(
   parameter int LANES     = 4,
   parameter int DATA_W    = 8,
   parameter int STAGES    = 2,
   parameter int GATE_MODE = 0,
   parameter int CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES-1:0]         in_pred,
   input  logic [LANES*DATA_W-1:0]  in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*DATA_W-1:0]  out_data,
   output logic [CNT_W-1:0]         gated_cnt
);

   localparam int DW = LANES * DATA_W;
   localparam int W0 = DW + LANES;
   localparam gate_mode_e MODE = (GATE_MODE != 0) ? GATE_HOLD : GATE_AND;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [STAGES:0]   w_rdy;
   logic [STAGES-1:0] w_v;
   logic [DW-1:0]     w_d [STAGES];
   logic [W0-1:0]     w_s0;
   logic [LANES-1:0]  w_p0;
   logic [DW-1:0]     w_gated;
   logic              w_xfer;

   logic [DW-1:0]     r_hold;
   logic [CNT_W-1:0]  r_cnt;

   assign w_rdy[STAGES] = out_ready;
   assign in_ready      = w_rdy[0];
   assign w_d[0]        = w_s0[DW-1:0];
   assign w_p0          = w_s0[W0-1:DW];
   assign w_xfer        = w_v[0] & w_rdy[1];

   genvar g;
   generate
      for (g = 0; g < STAGES; g++) begin : g_stage
         if (g == 0) begin : g_first
            // Stage 0 also carries the predicate up to the gate point.
            gate_pipe_stage #(.W(W0)) u_stage (
               .clk     (clk),
               .rst     (rst),
               .i_valid (in_valid),
               .i_data  ({in_pred, in_data}),
               .o_ready (w_rdy[0]),
               .o_valid (w_v[0]),
               .o_data  (w_s0),
               .i_ready (w_rdy[1])
            );
         end else begin : g_rest
            gate_pipe_stage #(.W(DW)) u_stage (
               .clk     (clk),
               .rst     (rst),
               .i_valid (w_v[g-1]),
               .i_data  ((g == 1) ? w_gated : w_d[g-1]),
               .o_ready (w_rdy[g]),
               .o_valid (w_v[g]),
               .o_data  (w_d[g]),
               .i_ready (w_rdy[g+1])
            );
         end
      end
   endgenerate

   always_comb begin
      w_gated = '0;
      for (int l = 0; l < LANES; l++) begin
         if (w_p0[l]) begin
            w_gated[lane_lsb(l, DATA_W) +: DATA_W] = w_d[0][lane_lsb(l, DATA_W) +: DATA_W];
         end else if (MODE == GATE_HOLD) begin
            w_gated[lane_lsb(l, DATA_W) +: DATA_W] = r_hold[lane_lsb(l, DATA_W) +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold <= '0;
      end else if (w_xfer) begin
         for (int l = 0; l < LANES; l++) begin
            if (w_p0[l]) begin
               r_hold[lane_lsb(l, DATA_W) +: DATA_W] <= w_d[0][lane_lsb(l, DATA_W) +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_xfer && !(&w_p0) && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign out_valid = w_v[STAGES-1];
   assign out_data  = w_d[STAGES-1];
   assign gated_cnt = r_cnt;

`ifdef ASSERT_ON
   logic             r_in_stall;
   logic [LANES-1:0] r_pred_q;
   logic [DW-1:0]    r_data_q;

   always_ff @(posedge clk) begin
      r_in_stall <= !rst && in_valid && !in_ready;
      r_pred_q   <= in_pred;
      r_data_q   <= in_data;
   end

   always @(posedge clk) begin
      if (!rst && r_in_stall) begin
         assert (in_valid && (in_pred == r_pred_q) && (in_data == r_data_q))
            else $error("stalled input beat changed before acceptance");
      end
      if (!rst) begin
         assert (!$isunknown(out_valid)) else $error("out_valid is X");
      end
      if (!rst && w_v[0] && (MODE == GATE_AND)) begin
         for (int l = 0; l < LANES; l++) begin
            if (!w_p0[l]) begin
               assert (w_gated[lane_lsb(l, DATA_W) +: DATA_W] == '0)
                  else $error("AND gate passed data on a disabled lane");
            end
         end
      end
   end
`endif

endmodule
